h264intra_nxn_controller: RTL and testbench
===========================================

Name: h264intra_nxn_controller

Overview:
Parametrised intra-prediction sequencing controller for the H.264 luma intra path. It walks the sub-blocks of one macroblock in z-order for 4x4 or 8x8 partitioning. For each sub-block it sequences cost accumulation, picks the cheapest available mode out of NMODES candidates, and encodes it as prev/rem syntax. It then handshakes the result to the output stage and, on completion, hands off to the chroma path. It sits between the intra predictor/cost datapath and the CAVLC header stage.

Parameters:
BLK_LOG2, 2, sub-block size log2 (2 = 4x4 with 16 sub-blocks, 3 = 8x8 with 4 sub-blocks)
NMODES, 3, candidate modes (3 = V/H/DC; 4 adds mode 3 diagonal-down-left)
COST_W, 12, width of each per-mode cost
ACC_CYC, 4, cycles of cost accumulation per sub-block
OUT_CYC, 4, output-enable cycles per sub-block

Ports:
CLK  in  1  clock, rising edge
RESETN  in  1  asynchronous active-low reset
STROBEI  in  1  start-of-macroblock pulse
NEWSLICE  in  1  synchronous abort; clears availability
TOPVALID  in  1  macroblock above is available
LEFTVALID  in  1  macroblock to the left is available
DCONLY  in  1  force DC mode
COSTS  in  NMODES*COST_W  packed mode costs; mode m occupies bits [m*COST_W +: COST_W]
PREVMODE  in  4  neighbour-predicted mode before the availability override
READYO  in  1  downstream can accept
FBSTROBE  in  1  feedback write in progress (stall)
SUBMB  out  4  current sub-block index (z-order)
TOTDIF_RST  out  1  clear the cost accumulators
TOTDIF_EN  out  1  accumulate costs
MODEO  out  4  chosen mode (registered)
MODEVALID  out  1  one-cycle pulse, first output cycle
PMODEFLAG  out  1  prev_intra_pred_mode_flag
REMMODE  out  3  rem_intra_pred_mode
OUTEN  out  1  output datapath enable
XXINC  out  1  one-cycle macroblock-done pulse
CHREADY  out  1  chroma may start; held until the next STROBEI
BUSY  out  1  state != IDLE

Behaviour:
- Reset: every output is 0, state is IDLE, SUBMB = 0, MODEO = 2.
- Index mapping: NSUB = 16 (BLK_LOG2 = 2) or 4 (BLK_LOG2 = 3). xx = even bits of SUBMB and yy = odd bits (4x4: xx = {b2,b0}, yy = {b3,b1}; 8x8: xx = b0, yy = b1).
- Availability: top = TOPVALID or yy != 0; left = LEFTVALID or xx != 0. Both are latched at STROBEI.
- Mode eligibility:
  - mode 0 requires top
  - mode 1 requires left
  - mode 2 is always eligible
  - mode 3 requires top, and exists only if NMODES = 4
  - DCONLY makes only mode 2 eligible.
- Decision: minimum cost among eligible modes, unsigned compare. Ties go to the lowest mode index. The chosen mode registers into MODEO in DECIDE.
- Syntax encoding: pred = 2 if !(top && left), else PREVMODE. PMODEFLAG = (MODEO == pred). REMMODE = MODEO if MODEO < pred, else MODEO - 1. Don't-care when PMODEFLAG = 1, but driven as 0.
- State machine:
  - IDLE: on STROBEI, SUBMB := 0, CHREADY := 0, go to PRIME.
  - PRIME (1 cycle): TOTDIF_RST = 1, go to ACCUM.
  - ACCUM: TOTDIF_EN = 1 for exactly ACC_CYC cycles (down-counter), then DECIDE.
  - DECIDE (1 cycle): latch MODEO, PMODEFLAG, REMMODE, go to WAIT.
  - WAIT: hold while !READYO or FBSTROBE; otherwise go to EMIT.
  - EMIT: OUTEN = 1 for OUT_CYC cycles; MODEVALID = 1 on the first cycle only. READYO dropping mid-EMIT does not stall. Then go to ADV.
  - ADV (1 cycle): if SUBMB == NSUB-1, go to DONE; else SUBMB += 1 and go to PRIME.
  - DONE (1 cycle): XXINC = 1, CHREADY := 1, go to IDLE.
- Per-sub-block latency with no stalls: 1 + ACC_CYC + 1 + 1 + OUT_CYC + 1 cycles (12 with defaults). One macroblock at 4x4 with defaults takes 16*12 + 1 = 193 cycles.
- NEWSLICE, any state: next state is IDLE, SUBMB = 0, latched availability = 0, and no XXINC is issued. NEWSLICE takes priority over STROBEI in the same cycle.
- STROBEI while BUSY is ignored.
- RESETN asserted mid-operation: immediate return to reset values.

Test Plan:
- 4x4, TOPVALID = LEFTVALID = 1, COSTS {m0 = 10, m1 = 20, m2 = 30}, PREVMODE = 1, READYO = 1 -> every sub-block gives MODEO = 0, PMODEFLAG = 0, REMMODE = 0. XXINC pulses at cycle 193 after STROBEI; 16 MODEVALID pulses total.
- TOPVALID = LEFTVALID = 0, costs {5, 5, 100}, PREVMODE = 0 -> SUBMB 0 gives MODEO = 2, PMODEFLAG = 1 (pred forced to 2). SUBMB 1 (xx = 1, top unavailable) gives MODEO = 1, PMODEFLAG = 0, REMMODE = 1.
- Tie costs {7, 7, 7}, both neighbours available -> MODEO = 0. Repeat with DCONLY = 1 -> MODEO = 2.
- Hold READYO = 0 for 5 cycles in WAIT, then raise it, and pulse FBSTROBE for 2 cycles -> no OUTEN until READYO = 1 and FBSTROBE = 0; exactly OUT_CYC OUTEN cycles follow.
- BLK_LOG2 = 3, NMODES = 4, costs {9, 9, 9, 3} with top available -> MODEO = 3. Exactly 4 sub-blocks run, then XXINC; CHREADY holds 1 until the next STROBEI.
- NEWSLICE asserted during ACCUM of SUBMB = 5 -> next cycle IDLE, SUBMB = 0, BUSY = 0, no XXINC. RESETN low mid-EMIT -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/h264intra_nxn_controller.sv
// Intra NxN sequencing controller: walks one macroblock's sub-blocks in z-order,
// picks the cheapest eligible luma mode per sub-block and emits prev/rem syntax.
module h264intra_nxn_controller #(
  parameter int BLK_LOG2 = 2,
  parameter int NMODES   = 3,
  parameter int COST_W   = 12,
  parameter int ACC_CYC  = 4,
  parameter int OUT_CYC  = 4
) (
  input  logic                     CLK,
  input  logic                     RESETN,
  input  logic                     STROBEI,
  input  logic                     NEWSLICE,
  input  logic                     TOPVALID,
  input  logic                     LEFTVALID,
  input  logic                     DCONLY,
  input  logic [NMODES*COST_W-1:0] COSTS,
  input  logic [3:0]               PREVMODE,
  input  logic                     READYO,
  input  logic                     FBSTROBE,
  output logic [3:0]               SUBMB,
  output logic                     TOTDIF_RST,
  output logic                     TOTDIF_EN,
  output logic [3:0]               MODEO,
  output logic                     MODEVALID,
  output logic                     PMODEFLAG,
  output logic [2:0]               REMMODE,
  output logic                     OUTEN,
  output logic                     XXINC,
  output logic                     CHREADY,
  output logic                     BUSY
);

  localparam logic [3:0] LAST_SUB = (BLK_LOG2 == 2) ? 4'd15 : 4'd3;
  localparam int CNT_MAX = (ACC_CYC > OUT_CYC) ? ACC_CYC : OUT_CYC;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] ACC_LOAD = CNT_W'(ACC_CYC - 1);
  localparam logic [CNT_W-1:0] OUT_LOAD = CNT_W'(OUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PRIME, S_ACCUM, S_DECIDE, S_WAIT, S_EMIT, S_ADV, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       sub_q, sub_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             top_q, top_d;
  logic             left_q, left_d;
  logic [3:0]       mode_q, mode_d;
  logic             pflag_q, pflag_d;
  logic [2:0]       rem_q, rem_d;
  logic             chready_q, chready_d;

  logic             xxNz, yyNz, topAvail, leftAvail;
  logic [3:0]       bestMode, pred;
  logic [COST_W-1:0] bestCost;
  logic             found;
  logic             pflagNext;
  logic [2:0]       remNext;

  function automatic logic eligible(input int m, input logic top, input logic left,
                                    input logic dcOnly);
    logic e;
    e = 1'b0;
    if (dcOnly) e = (m == 2);
    else begin
      case (m)
        0:       e = top;
        1:       e = left;
        2:       e = 1'b1;
        3:       e = top;
        default: e = 1'b0;
      endcase
    end
    return e;
  endfunction

  // Neighbours inside the macroblock are always available; only the MB edge uses the latched flags.
  always_comb begin
    if (BLK_LOG2 == 2) begin
      xxNz = sub_q[2] | sub_q[0];
      yyNz = sub_q[3] | sub_q[1];
    end else begin
      xxNz = sub_q[0];
      yyNz = sub_q[1];
    end
    topAvail  = top_q | yyNz;
    leftAvail = left_q | xxNz;
  end

  // Strict less-than while scanning upward keeps ties on the lowest mode index.
  always_comb begin
    bestMode = 4'd2;
    bestCost = COSTS[2*COST_W +: COST_W];
    found    = 1'b0;
    for (int m = 0; m < NMODES; m++) begin
      if (eligible(m, topAvail, leftAvail, DCONLY) &&
          (!found || (COSTS[m*COST_W +: COST_W] < bestCost))) begin
        bestMode = 4'(m);
        bestCost = COSTS[m*COST_W +: COST_W];
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    pred      = (topAvail && leftAvail) ? PREVMODE : 4'd2;
    pflagNext = (bestMode == pred);
    if (pflagNext)           remNext = 3'd0;
    else if (bestMode < pred) remNext = bestMode[2:0];
    else                     remNext = 3'(bestMode - 4'd1);
  end

  always_comb begin
    state_d   = state_q;
    sub_d     = sub_q;
    cnt_d     = cnt_q;
    top_d     = top_q;
    left_d    = left_q;
    mode_d    = mode_q;
    pflag_d   = pflag_q;
    rem_d     = rem_q;
    chready_d = chready_q;
    case (state_q)
      S_IDLE: begin
        if (STROBEI) begin
          sub_d     = 4'd0;
          chready_d = 1'b0;
          top_d     = TOPVALID;
          left_d    = LEFTVALID;
          state_d   = S_PRIME;
        end
      end
      S_PRIME: begin
        cnt_d   = ACC_LOAD;
        state_d = S_ACCUM;
      end
      S_ACCUM: begin
        if (cnt_q == '0) state_d = S_DECIDE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_DECIDE: begin
        mode_d  = bestMode;
        pflag_d = pflagNext;
        rem_d   = remNext;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (READYO && !FBSTROBE) begin
          cnt_d   = OUT_LOAD;
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (cnt_q == '0) state_d = S_ADV;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_ADV: begin
        if (sub_q == LAST_SUB) state_d = S_DONE;
        else begin
          sub_d   = sub_q + 4'd1;
          state_d = S_PRIME;
        end
      end
      S_DONE: begin
        chready_d = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Slice abort overrides everything, including a same-cycle start.
    if (NEWSLICE) begin
      state_d   = S_IDLE;
      sub_d     = 4'd0;
      top_d     = 1'b0;
      left_d    = 1'b0;
      chready_d = chready_q;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q   <= S_IDLE;
      sub_q     <= 4'd0;
      cnt_q     <= '0;
      top_q     <= 1'b0;
      left_q    <= 1'b0;
      mode_q    <= 4'd2;
      pflag_q   <= 1'b0;
      rem_q     <= 3'd0;
      chready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sub_q     <= sub_d;
      cnt_q     <= cnt_d;
      top_q     <= top_d;
      left_q    <= left_d;
      mode_q    <= mode_d;
      pflag_q   <= pflag_d;
      rem_q     <= rem_d;
      chready_q <= chready_d;
    end
  end

  assign SUBMB      = sub_q;
  assign TOTDIF_RST = (state_q == S_PRIME);
  assign TOTDIF_EN  = (state_q == S_ACCUM);
  assign MODEO      = mode_q;
  assign MODEVALID  = (state_q == S_EMIT) && (cnt_q == OUT_LOAD);
  assign PMODEFLAG  = pflag_q;
  assign REMMODE    = rem_q;
  assign OUTEN      = (state_q == S_EMIT);
  assign XXINC      = (state_q == S_DONE);
  assign CHREADY    = chready_q;
  assign BUSY       = (state_q != S_IDLE);

endmodule

// File: tb/tb_h264intra_nxn_controller.sv
// Directed bench for the intra NxN controller: 4x4/3-mode instance plus an 8x8/4-mode instance.
module tb_h264intra_nxn_controller;

  logic        CLK = 1'b0;
  logic        RESETN, STROBEI, STROBE8, NEWSLICE, TOPVALID, LEFTVALID, DCONLY;
  logic        READYO, FBSTROBE;
  logic [35:0] COSTS;
  logic [47:0] COSTS8;
  logic [3:0]  PREVMODE;

  logic [3:0] SUBMB, MODEO, SUBMB8, MODEO8;
  logic [2:0] REMMODE, REMMODE8;
  logic TOTDIF_RST, TOTDIF_EN, MODEVALID, PMODEFLAG, OUTEN, XXINC, CHREADY, BUSY;
  logic TOTDIF_RST8, TOTDIF_EN8, MODEVALID8, PMODEFLAG8, OUTEN8, XXINC8, CHREADY8, BUSY8;

  int total = 0;
  int bad   = 0;
  int cyc, cnt, cnt2;
  bit ok;

  always #5 CLK = ~CLK;

  h264intra_nxn_controller dut (
    .CLK(CLK), .RESETN(RESETN), .STROBEI(STROBEI), .NEWSLICE(NEWSLICE),
    .TOPVALID(TOPVALID), .LEFTVALID(LEFTVALID), .DCONLY(DCONLY), .COSTS(COSTS),
    .PREVMODE(PREVMODE), .READYO(READYO), .FBSTROBE(FBSTROBE), .SUBMB(SUBMB),
    .TOTDIF_RST(TOTDIF_RST), .TOTDIF_EN(TOTDIF_EN), .MODEO(MODEO), .MODEVALID(MODEVALID),
    .PMODEFLAG(PMODEFLAG), .REMMODE(REMMODE), .OUTEN(OUTEN), .XXINC(XXINC),
    .CHREADY(CHREADY), .BUSY(BUSY)
  );

  h264intra_nxn_controller #(.BLK_LOG2(3), .NMODES(4)) dut8 (
    .CLK(CLK), .RESETN(RESETN), .STROBEI(STROBE8), .NEWSLICE(NEWSLICE),
    .TOPVALID(TOPVALID), .LEFTVALID(LEFTVALID), .DCONLY(DCONLY), .COSTS(COSTS8),
    .PREVMODE(PREVMODE), .READYO(READYO), .FBSTROBE(FBSTROBE), .SUBMB(SUBMB8),
    .TOTDIF_RST(TOTDIF_RST8), .TOTDIF_EN(TOTDIF_EN8), .MODEO(MODEO8), .MODEVALID(MODEVALID8),
    .PMODEFLAG(PMODEFLAG8), .REMMODE(REMMODE8), .OUTEN(OUTEN8), .XXINC(XXINC8),
    .CHREADY(CHREADY8), .BUSY(BUSY8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic strobe();
    STROBEI = 1'b1;
    tick();
    STROBEI = 1'b0;
  endtask

  task automatic abortSlice();
    NEWSLICE = 1'b1;
    tick();
    NEWSLICE = 1'b0;
  endtask

  task automatic waitMv(output bit found);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (MODEVALID === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    RESETN = 1'b0; STROBEI = 1'b0; STROBE8 = 1'b0; NEWSLICE = 1'b0;
    TOPVALID = 1'b0; LEFTVALID = 1'b0; DCONLY = 1'b0; READYO = 1'b1; FBSTROBE = 1'b0;
    COSTS = '0; COSTS8 = '0; PREVMODE = 4'd0;
    #23;
    chk("rstSubmb", 32'(SUBMB), 32'd0);
    chk("rstModeo", 32'(MODEO), 32'd2);
    chk("rstBusy", 32'(BUSY), 32'd0);
    chk("rstCtrl", 32'({TOTDIF_RST, TOTDIF_EN, MODEVALID, PMODEFLAG, REMMODE, OUTEN, XXINC, CHREADY}), 32'd0);
    @(negedge CLK);
    RESETN = 1'b1;
    tick();

    // Full 4x4 macroblock, both neighbours, mode 0 cheapest
    TOPVALID = 1'b1; LEFTVALID = 1'b1; PREVMODE = 4'd1;
    COSTS = {12'd30, 12'd20, 12'd10};
    strobe();
    cyc = 1; cnt = 0; cnt2 = 0;
    chk("primeRst", 32'(TOTDIF_RST), 32'd1);
    chk("busyStart", 32'(BUSY), 32'd1);
    while (cyc < 300) begin
      tick();
      cyc++;
      if (cyc == 2) chk("accumEn", 32'(TOTDIF_EN), 32'd1);
      if (OUTEN === 1'b1) cnt2++;
      if (MODEVALID === 1'b1) begin
        cnt++;
        chk("mb1Mode", 32'({MODEO, PMODEFLAG, REMMODE}), 32'({4'd0, 1'b0, 3'd0}));
      end
      if (XXINC === 1'b1) break;
    end
    chk("mb1XxincCycle", 32'(cyc), 32'd193);
    chk("mb1MvCount", 32'(cnt), 32'd16);
    chk("mb1OutenCount", 32'(cnt2), 32'd64);
    tick();
    chk("mb1XxincPulse", 32'(XXINC), 32'd0);
    chk("mb1Chready", 32'(CHREADY), 32'd1);
    chk("mb1Idle", 32'(BUSY), 32'd0);

    // No neighbours: edge sub-blocks restricted, pred forced to DC
    TOPVALID = 1'b0; LEFTVALID = 1'b0; PREVMODE = 4'd0;
    COSTS = {12'd100, 12'd5, 12'd5};
    strobe();
    chk("strobeClrChready", 32'(CHREADY), 32'd0);
    waitMv(ok);
    chk("sub0Seen", 32'(ok), 32'd1);
    chk("sub0Index", 32'(SUBMB), 32'd0);
    chk("sub0Mode", 32'({MODEO, PMODEFLAG, REMMODE}), 32'({4'd2, 1'b1, 3'd0}));
    waitMv(ok);
    chk("sub1Seen", 32'(ok), 32'd1);
    chk("sub1Index", 32'(SUBMB), 32'd1);
    chk("sub1Mode", 32'({MODEO, PMODEFLAG, REMMODE}), 32'({4'd1, 1'b0, 3'd1}));

    // Abort during ACCUM of sub-block 5
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (SUBMB === 4'd5 && TOTDIF_EN === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk("reachSub5", 32'(ok), 32'd1);
    abortSlice();
    chk("abortBusy", 32'(BUSY), 32'd0);
    chk("abortSubmb", 32'(SUBMB), 32'd0);
    chk("abortXxinc", 32'(XXINC), 32'd0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (XXINC === 1'b1 || BUSY === 1'b1) cnt++;
    end
    chk("abortStaysIdle", 32'(cnt), 32'd0);

    // Equal costs go to mode 0; DCONLY forces mode 2
    TOPVALID = 1'b1; LEFTVALID = 1'b1; PREVMODE = 4'd0;
    COSTS = {12'd7, 12'd7, 12'd7};
    strobe();
    waitMv(ok);
    chk("tieSeen", 32'(ok), 32'd1);
    chk("tieMode", 32'({MODEO, PMODEFLAG, REMMODE}), 32'({4'd0, 1'b1, 3'd0}));
    abortSlice();
    DCONLY = 1'b1;
    strobe();
    waitMv(ok);
    chk("dcSeen", 32'(ok), 32'd1);
    chk("dcMode", 32'({MODEO, PMODEFLAG, REMMODE}), 32'({4'd2, 1'b0, 3'd1}));
    abortSlice();
    DCONLY = 1'b0;

    // Output stall: READYO low, then FBSTROBE, then release
    READYO = 1'b0;
    strobe();
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (OUTEN === 1'b1) cnt++;
    end
    chk("stallReady", 32'(cnt), 32'd0);
    READYO = 1'b1; FBSTROBE = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (OUTEN === 1'b1) cnt++;
    end
    chk("stallFb", 32'(cnt), 32'd0);
    FBSTROBE = 1'b0;
    cnt = 0; cnt2 = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (OUTEN === 1'b1) cnt++;
      if (MODEVALID === 1'b1) cnt2++;
      if (i == 0) begin
        chk("emitStart", 32'(OUTEN), 32'd1);
        READYO = 1'b0;
      end
    end
    chk("emitCount", 32'(cnt), 32'd4);
    chk("emitMvCount", 32'(cnt2), 32'd1);
    READYO = 1'b1;
    abortSlice();

    // 8x8 with four modes: diagonal-down-left cheapest
    PREVMODE = 4'd0;
    COSTS8 = {12'd3, 12'd9, 12'd9, 12'd9};
    STROBE8 = 1'b1;
    tick();
    STROBE8 = 1'b0;
    cyc = 1; cnt = 0;
    while (cyc < 120) begin
      tick();
      cyc++;
      if (MODEVALID8 === 1'b1) begin
        cnt++;
        chk("b8Mode", 32'({MODEO8, PMODEFLAG8, REMMODE8}), 32'({4'd3, 1'b0, 3'd2}));
      end
      if (XXINC8 === 1'b1) break;
    end
    chk("b8XxincCycle", 32'(cyc), 32'd49);
    chk("b8MvCount", 32'(cnt), 32'd4);
    for (int i = 0; i < 6; i++) tick();
    chk("b8ChreadyHeld", 32'(CHREADY8), 32'd1);
    STROBE8 = 1'b1;
    tick();
    STROBE8 = 1'b0;
    chk("b8ChreadyClr", 32'(CHREADY8), 32'd0);
    abortSlice();

    // Asynchronous reset in the middle of EMIT
    COSTS = {12'd30, 12'd20, 12'd10};
    strobe();
    for (int i = 0; i < 8; i++) tick();
    chk("preRstOuten", 32'(OUTEN), 32'd1);
    chk("preRstMode", 32'(MODEO), 32'd0);
    #2;
    RESETN = 1'b0;
    #1;
    chk("asyncRstOuten", 32'(OUTEN), 32'd0);
    chk("asyncRstBusy", 32'(BUSY), 32'd0);
    chk("asyncRstState", 32'({SUBMB, MODEO, PMODEFLAG, REMMODE, MODEVALID}), 32'({4'd0, 4'd2, 1'b0, 3'd0, 1'b0}));
    @(negedge CLK);
    RESETN = 1'b1;
    tick();
    chk("postRstIdle", 32'(BUSY), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
